// File: rtl/scanline_irq_unit_pkg.sv
// Shared types and constants for the scanline IRQ unit.
// Contents: FSM state type, nametable select pattern, scanline match
// requirement, PPU address width and a channel-index width helper.
package scanline_irq_unit_pkg;

  typedef enum logic {
    SL_IDLE     = 1'b0,
    SL_IN_FRAME = 1'b1
  } sl_state_t;

  localparam logic [1:0]  NT_SEL     = 2'b10;
  localparam int unsigned MATCH_REQ  = 2;
  localparam int unsigned PPU_ADDR_W = 14;

  // Index width for n channels, never below one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/scanline_irq_unit_if.sv
// CPU-side register bus of the scanline IRQ unit.
// master: CPU/mapper side  - drives cmp_we/cmp_sel/cmp_val, mask_we/mask_val,
//                            status_rd; observes line_cnt, in_frame, irq_pend, irq.
// slave:  scanline unit    - the reverse directions.
interface scanline_irq_unit_if
  import scanline_irq_unit_pkg::*;
#(
  parameter int unsigned CH_NUM = 2,
  parameter int unsigned CNT_W  = 8
);
  localparam int unsigned CH_IDX_W = idx_w(CH_NUM);

  logic                cmp_we;
  logic [CH_IDX_W-1:0] cmp_sel;
  logic [CNT_W-1:0]    cmp_val;
  logic                mask_we;
  logic [CH_NUM-1:0]   mask_val;
  logic                status_rd;

  logic [CNT_W-1:0]    line_cnt;
  logic                in_frame;
  logic [CH_NUM-1:0]   irq_pend;
  logic                irq;

  modport master (
    output cmp_we, cmp_sel, cmp_val, mask_we, mask_val, status_rd,
    input  line_cnt, in_frame, irq_pend, irq
  );

  modport slave (
    input  cmp_we, cmp_sel, cmp_val, mask_we, mask_val, status_rd,
    output line_cnt, in_frame, irq_pend, irq
  );

endinterface

// File: rtl/scanline_irq_unit_edge_sync.sv
// N-flop synchroniser with a registered single-cycle edge pulse.
// Ports: clk, rst (sync, active-high), d_i (async level),
//        pulse_o (one clk pulse on the selected edge of the synchronised level).
// FALL_EDGE selects falling (1) or rising (0) edge; RST_VAL is the idle level
// of the input so that reset does not fabricate an edge.
// Pin-to-pulse latency is STAGES+1 clk.
module scanline_irq_unit_edge_sync #(
  parameter int unsigned STAGES    = 2,
  parameter bit          FALL_EDGE = 1'b0,
  parameter bit          RST_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic pulse_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              pulse_q;
  logic              lvl;

  assign lvl = sync_q[STAGES-1];

  // Synchroniser chain, edge history and registered pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= {STAGES{RST_VAL}};
      prev_q  <= RST_VAL;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= STAGES'({sync_q, d_i});
      prev_q  <= lvl;
      pulse_q <= FALL_EDGE ? (prev_q & ~lvl) : (~prev_q & lvl);
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/scanline_irq_unit.sv
// Scanline counter / IRQ generator for cartridge mappers, single clk domain.
// Detects scanline starts as three consecutive PPU reads of the same
// nametable address, tracks in-frame state and raises IRQs on CH_NUM
// line-compare channels.
// Ports:
//   clk, rst     system clock; synchronous active-high reset
//   m2_i         CPU M2 (async)
//   ppu_oe_i     PPU read strobe (async, active-low)
//   ppu_addr_i   PPU address (async, valid while ppu_oe_i low)
//   bgr_en_i     rendering enabled (clk domain)
//   bus          register bus (slave): compare/mask writes, status read,
//                line_cnt, in_frame, irq_pend, irq
//   frame_cnt_o  frame entry counter, only with SCANLINE_IRQ_FRAME_CNT_EN
module scanline_irq_unit
  import scanline_irq_unit_pkg::*;
#(
  parameter int unsigned CH_NUM      = 2,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned TIMEOUT_M2  = 3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m2_i,
  input  logic                  ppu_oe_i,
  input  logic [PPU_ADDR_W-1:0] ppu_addr_i,
  input  logic                  bgr_en_i,
`ifdef SCANLINE_IRQ_FRAME_CNT_EN
  output logic [7:0]            frame_cnt_o,
`endif
  scanline_irq_unit_if.slave    bus
);

  localparam int unsigned CH_IDX_W = idx_w(CH_NUM);
  localparam int unsigned MATCH_W  = $clog2(MATCH_REQ + 1);
  localparam int unsigned IDLE_W   = $clog2(TIMEOUT_M2 + 1);

  logic                  oe_fall;
  logic                  m2_rise;
  logic [PPU_ADDR_W-1:0] addr_dly_q [SYNC_STAGES+1];
  logic [PPU_ADDR_W-1:0] rd_addr;
  logic [PPU_ADDR_W-1:0] last_addr_q;
  logic [MATCH_W-1:0]    match_q, match_d;
  logic [IDLE_W-1:0]     idle_q, idle_d;
  logic                  addr_match;
  logic                  line_edge;
  logic                  timeout;
  logic [CNT_W-1:0]      cmp_q [CH_NUM];
  logic [CH_NUM-1:0]     hit;
  sl_state_t             state_q, state_d;
  logic [CNT_W-1:0]      line_q, line_d, line_inc;
  logic [CH_NUM-1:0]     pend_q, pend_d;
  logic [CH_NUM-1:0]     mask_q;
  logic                  in_frame_q;
  logic                  irq_q;

  scanline_irq_unit_edge_sync #(
    .STAGES(SYNC_STAGES), .FALL_EDGE(1'b1), .RST_VAL(1'b1)
  ) u_oe_sync (
    .clk(clk), .rst(rst), .d_i(ppu_oe_i), .pulse_o(oe_fall)
  );

  scanline_irq_unit_edge_sync #(
    .STAGES(SYNC_STAGES), .FALL_EDGE(1'b0), .RST_VAL(1'b0)
  ) u_m2_sync (
    .clk(clk), .rst(rst), .d_i(m2_i), .pulse_o(m2_rise)
  );

  // Address delay line, one stage deeper than the synchroniser so the
  // captured address lines up with the registered read pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES + 1; i++) addr_dly_q[i] <= '0;
    end else begin
      addr_dly_q[0] <= ppu_addr_i;
      for (int i = 1; i < SYNC_STAGES + 1; i++) addr_dly_q[i] <= addr_dly_q[i-1];
    end
  end

  assign rd_addr    = addr_dly_q[SYNC_STAGES];
  assign addr_match = (rd_addr[PPU_ADDR_W-1 -: 2] == NT_SEL) && (rd_addr == last_addr_q);
  assign line_edge  = oe_fall && addr_match && (match_q == MATCH_W'(MATCH_REQ - 1));
  assign timeout    = (idle_q == IDLE_W'(TIMEOUT_M2));
  assign line_inc   = line_q + CNT_W'(1);

  // Repeat-read counter and m2 idle counter.
  always_comb begin
    match_d = match_q;
    idle_d  = idle_q;
    if (oe_fall) begin
      if (line_edge || !addr_match)              match_d = '0;
      else if (match_q != MATCH_W'(MATCH_REQ))   match_d = match_q + MATCH_W'(1);
    end
    if (oe_fall)                idle_d = '0;
    else if (m2_rise && !timeout) idle_d = idle_q + IDLE_W'(1);
  end

  // Compare channels; a channel hits when the incremented line equals its value.
  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    always_ff @(posedge clk) begin
      if (rst)                                                cmp_q[g] <= '0;
      else if (bus.cmp_we && (bus.cmp_sel == CH_IDX_W'(g)))   cmp_q[g] <= bus.cmp_val;
    end
    assign hit[g] = (cmp_q[g] != '0) && (line_inc == cmp_q[g]);
  end

  // Frame FSM next state, line counter and pending flags.
  // A saturated counter does not advance, so it cannot re-fire a compare.
  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    pend_d  = pend_q & ~{CH_NUM{bus.status_rd}};
    case (state_q)
      SL_IDLE: begin
        if (line_edge && bgr_en_i) begin
          state_d = SL_IN_FRAME;
          line_d  = '0;
          pend_d  = '0;
        end
      end
      SL_IN_FRAME: begin
        if (timeout || !bgr_en_i) begin
          state_d = SL_IDLE;
          line_d  = '0;
        end else if (line_edge && (line_q != '1)) begin
          line_d = line_inc;
          pend_d = pend_d | hit;
        end
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SL_IDLE;
      line_q      <= '0;
      pend_q      <= '0;
      mask_q      <= '0;
      in_frame_q  <= 1'b0;
      irq_q       <= 1'b0;
      last_addr_q <= '0;
      match_q     <= '0;
      idle_q      <= '0;
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      pend_q     <= pend_d;
      in_frame_q <= (state_d == SL_IN_FRAME);
      irq_q      <= |(pend_q & mask_q);
      match_q    <= match_d;
      idle_q     <= idle_d;
      if (oe_fall)     last_addr_q <= rd_addr;
      if (bus.mask_we) mask_q      <= bus.mask_val;
    end
  end

`ifdef SCANLINE_IRQ_FRAME_CNT_EN
  logic [7:0] frame_q;
  logic       frame_enter;

  assign frame_enter = (state_q == SL_IDLE) && (state_d == SL_IN_FRAME);

  // Frame entry counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst)              frame_q <= '0;
    else if (frame_enter) frame_q <= frame_q + 8'(1);
  end

  assign frame_cnt_o = frame_q;
`else
  // Frame entry counter not built.
`endif

  assign bus.line_cnt = line_q;
  assign bus.in_frame = in_frame_q;
  assign bus.irq_pend = pend_q;
  assign bus.irq      = irq_q;

endmodule

// File: tb/tb_scanline_irq_unit.sv
// Directed self-checking bench for scanline_irq_unit with a model-fed scoreboard.
module tb_scanline_irq_unit;

  localparam int unsigned S  = 2;
  localparam int unsigned CH = 2;
  localparam int unsigned CW = 8;
  localparam int unsigned TO = 3;

  typedef struct packed {
    logic       inf;
    logic [7:0] line;
    logic [1:0] pend;
    logic       irq;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        m2;
  logic        ppu_oe;
  logic [13:0] ppu_addr;
  logic        bgr_en;
`ifdef SCANLINE_IRQ_FRAME_CNT_EN
  logic [7:0]  frame_cnt;
`endif

  int checks = 0;
  int errors = 0;

  exp_t       sb[$];
  logic       obs_inf  [1:8];
  logic [1:0] obs_pend [1:8];
  logic       obs_irq  [1:8];

  logic       m_inf;
  logic [7:0] m_line;
  logic [1:0] m_pend;
  logic [1:0] m_mask;
  logic [7:0] m_cmp [2];
  logic [7:0] m_fc;

  scanline_irq_unit_if #(.CH_NUM(CH), .CNT_W(CW)) bus ();

  scanline_irq_unit #(
    .CH_NUM(CH), .CNT_W(CW), .TIMEOUT_M2(TO), .SYNC_STAGES(S)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .m2_i       (m2),
    .ppu_oe_i   (ppu_oe),
    .ppu_addr_i (ppu_addr),
    .bgr_en_i   (bgr_en),
`ifdef SCANLINE_IRQ_FRAME_CNT_EN
    .frame_cnt_o(frame_cnt),
`endif
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One PPU read: strobe low for 3 clk, high for 5; optional status read
  // aligned with the cycle in which the read becomes a line event.
  task automatic rd(input logic [13:0] a, input bit srd);
    ppu_addr = a;
    ppu_oe   = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      obs_inf[i]    = bus.in_frame;
      obs_pend[i]   = bus.irq_pend;
      obs_irq[i]    = bus.irq;
      bus.status_rd = srd && (i == S + 1);
      if (i == 3) ppu_oe = 1'b1;
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.inf  = m_inf;
    e.line = m_line;
    e.pend = m_pend;
    e.irq  = |(m_pend & m_mask);
    sb.push_back(e);
  endtask

  task automatic check_sb(input string tag);
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, ".in_frame"}, 32'(bus.in_frame), 32'(e.inf));
      chk({tag, ".line_cnt"}, 32'(bus.line_cnt), 32'(e.line));
      chk({tag, ".irq_pend"}, 32'(bus.irq_pend), 32'(e.pend));
      chk({tag, ".irq"},      32'(bus.irq),      32'(e.irq));
    end
  endtask

  // Reference behaviour of one detected scanline start.
  task automatic model_line(input bit srd);
    logic [1:0] set;
    set = 2'b00;
    if (!m_inf) begin
      if (bgr_en) begin
        m_inf  = 1'b1;
        m_line = 8'd0;
        m_pend = 2'b00;
        m_fc   = m_fc + 8'd1;
      end
    end else if (m_line != 8'hFF) begin
      m_line = m_line + 8'd1;
      for (int i = 0; i < 2; i++)
        if (m_cmp[i] != 8'd0 && m_line == m_cmp[i]) set[i] = 1'b1;
    end
    if (srd) m_pend = 2'b00;
    m_pend = m_pend | set;
  endtask

  // Scanline: a pattern read breaks any run, then three nametable reads.
  task automatic line(input string tag, input bit track, input bit srd);
    model_line(srd);
    if (track) push_exp();
    rd(14'h0010, 1'b0);
    rd(14'h2000, 1'b0);
    rd(14'h2000, 1'b0);
    rd(14'h2000, srd);
    if (track) check_sb(tag);
  endtask

  task automatic wr_cmp(input int ch, input logic [7:0] v);
    bus.cmp_sel = 1'(ch);
    bus.cmp_val = v;
    bus.cmp_we  = 1'b1;
    tick();
    bus.cmp_we  = 1'b0;
    m_cmp[ch]   = v;
  endtask

  task automatic wr_mask(input logic [1:0] v);
    bus.mask_val = v;
    bus.mask_we  = 1'b1;
    tick();
    bus.mask_we  = 1'b0;
    m_mask       = v;
  endtask

  task automatic status_read();
    bus.status_rd = 1'b1;
    tick();
    bus.status_rd = 1'b0;
    tick();
    m_pend = 2'b00;
  endtask

  task automatic m2_pulse();
    m2 = 1'b1;
    repeat (3) tick();
    m2 = 1'b0;
    repeat (3) tick();
  endtask

  task automatic model_reset();
    m_inf = 1'b0; m_line = 8'd0; m_pend = 2'b00; m_mask = 2'b00;
    m_cmp[0] = 8'd0; m_cmp[1] = 8'd0; m_fc = 8'd0;
  endtask

  initial begin
    rst = 1'b1; m2 = 1'b0; ppu_oe = 1'b1; ppu_addr = 14'h0; bgr_en = 1'b1;
    bus.cmp_we = 1'b0; bus.cmp_sel = '0; bus.cmp_val = '0;
    bus.mask_we = 1'b0; bus.mask_val = '0; bus.status_rd = 1'b0;
    model_reset();
    repeat (3) tick();

    // Reset state
    push_exp();
    check_sb("reset");
`ifdef SCANLINE_IRQ_FRAME_CNT_EN
    chk("reset.frame_cnt", 32'(frame_cnt), 32'(m_fc));
`endif
    rst = 1'b0;
    repeat (4) tick();

    // 1: frame entry and its latency from the third read
    line("t1_enter", 1'b1, 1'b0);
    chk("t1_lat_pre", 32'(obs_inf[S+1]), 32'd0);
    chk("t1_lat",     32'(obs_inf[S+2]), 32'd1);

    // 2: compare on line 5, irq one clk after pend, status read clears
    wr_cmp(0, 8'd5);
    wr_mask(2'b01);
    for (int k = 0; k < 4; k++) line("", 1'b0, 1'b0);
    line("t2_l5", 1'b1, 1'b0);
    chk("t2_pend_pre",  32'(obs_pend[S+1]), 32'd0);
    chk("t2_pend_set",  32'(obs_pend[S+2]), 32'd1);
    chk("t2_irq_pre",   32'(obs_irq[S+2]),  32'd0);
    chk("t2_irq_set",   32'(obs_irq[S+3]),  32'd1);
    status_read();
    push_exp();
    check_sb("t2_srd");

    // 3: broken runs and pattern-table reads do not count
    push_exp();
    rd(14'h0010, 1'b0);
    rd(14'h2000, 1'b0);
    rd(14'h2000, 1'b0);
    rd(14'h23C0, 1'b0);
    rd(14'h2000, 1'b0);
    check_sb("t3_broken");
    push_exp();
    rd(14'h1FF0, 1'b0);
    rd(14'h1FF0, 1'b0);
    rd(14'h1FF0, 1'b0);
    rd(14'h1FF0, 1'b0);
    check_sb("t3_pattern");
    line("t3_resume", 1'b1, 1'b0);

    // 4: m2 timeout keeps pend; bgr_en drop leaves at once
    wr_cmp(0, 8'd7);
    line("t4_l7", 1'b1, 1'b0);
    push_exp();
    m2_pulse();
    m2_pulse();
    check_sb("t4_two_m2");
    m_inf = 1'b0; m_line = 8'd0;
    push_exp();
    m2_pulse();
    tick();
    check_sb("t4_timeout");
    line("t4_reenter", 1'b1, 1'b0);
    line("t4_l1", 1'b1, 1'b0);
    bgr_en = 1'b0;
    m_inf = 1'b0; m_line = 8'd0;
    push_exp();
    tick();
    check_sb("t4_bgr_off");
    bgr_en = 1'b1;

    // 5: saturation at 255, set beats same-cycle status read, no re-fire
    wr_cmp(1, 8'd255);
    wr_mask(2'b11);
    line("t5_enter", 1'b1, 1'b0);
    for (int k = 0; k < 254; k++) line("", 1'b0, 1'b0);
    line("t5_l255", 1'b1, 1'b1);
    chk("t5_set_wins", 32'(obs_pend[S+2]), 32'd2);
    for (int k = 0; k < 44; k++) line("", 1'b0, 1'b0);
    line("t5_sat", 1'b1, 1'b0);
    status_read();
    push_exp();
    check_sb("t5_clear");
    line("t5_once", 1'b1, 1'b0);

    // 6: synchronous reset in the middle of a frame
    bgr_en = 1'b0;
    m_inf = 1'b0; m_line = 8'd0;
    tick();
    bgr_en = 1'b1;
    wr_cmp(0, 8'd1);
    line("t6_enter", 1'b1, 1'b0);
    line("t6_l1", 1'b1, 1'b0);
    rst = 1'b1;
    model_reset();
    push_exp();
    tick();
    check_sb("t6_rst");
`ifdef SCANLINE_IRQ_FRAME_CNT_EN
    chk("t6_rst.frame_cnt", 32'(frame_cnt), 32'd0);
`endif
    rst = 1'b0;
    repeat (4) tick();

`ifdef SCANLINE_IRQ_FRAME_CNT_EN
    // Frame counter wraps after 256 entries
    for (int k = 0; k < 256; k++) begin
      line("", 1'b0, 1'b0);
      if (k == 254) chk("t6_fc255", 32'(frame_cnt), 32'(m_fc));
      bgr_en = 1'b0;
      tick();
      m_inf = 1'b0; m_line = 8'd0;
      bgr_en = 1'b1;
    end
    chk("t6_fc_wrap", 32'(frame_cnt), 32'(m_fc));
`endif
    line("t6_after", 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
